// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// a constant clog2 helper for sizing the bit counter.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor z = x - y, LSB first, one bit per clock, behind a
// start/busy/done handshake. Define OVERFLOW_FLAG_EN to add a signed-overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic             borrow,
    output logic             busy,
`ifdef OVERFLOW_FLAG_EN
    output logic             overflow,
`endif
    output logic             done
);

    localparam int unsigned CNT_W = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_b;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

    full_subtractor u_cell (
        .a    (r_x[0]),
        .b    (r_y[0]),
        .bin  (r_b),
        .d    (w_d),
        .bout (w_bout)
    );

    // New difference bit enters at the MSB so the result ends up LSB-aligned.
    always_comb begin
        w_res_next            = r_res >> 1;
        w_res_next[WIDTH-1]   = w_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_b      <= 1'b0;
            z        <= '0;
            borrow   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_b     <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_x   <= r_x >> 1;
                    r_y   <= r_y >> 1;
                    r_b   <= w_bout;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        z        <= w_res_next;
                        borrow   <= w_bout;
`ifdef OVERFLOW_FLAG_EN
                        // On the last bit the operand LSBs hold the original sign bits.
                        overflow <= (r_x[0] != r_y[0]) && (w_d != r_x[0]);
`endif
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic [W-1:0] z;
    logic         borrow;
    logic         busy;
    logic         done;
`ifdef OVERFLOW_FLAG_EN
    logic         overflow;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x        (x),
        .y        (y),
        .z        (z),
        .borrow   (borrow),
        .busy     (busy),
`ifdef OVERFLOW_FLAG_EN
        .overflow (overflow),
`endif
        .done     (done)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic signed_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        int diff;
        sa   = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb   = b[W-1] ? int'(b) - (1 << W) : int'(b);
        diff = sa - sb;
        return (diff > (1 << (W - 1)) - 1) || (diff < -(1 << (W - 1)));
    endfunction

    // Reference model: countdown of remaining busy cycles, result from plain arithmetic.
    int           m_left = 0;
    logic [W-1:0] m_z = '0;
    logic [W-1:0] p_z = '0;
    logic         m_b = 1'b0;
    logic         p_b = 1'b0;
    logic         m_o = 1'b0;
    logic         p_o = 1'b0;
    logic         m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_z    <= '0;
            m_b    <= 1'b0;
            m_o    <= 1'b0;
            m_done <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_z    <= p_z;
                m_b    <= p_b;
                m_o    <= p_o;
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_left <= W;
                p_z    <= x - y;
                p_b    <= (x < y);
                p_o    <= signed_ovf(x, y);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_z", 32'(z), 32'(m_z));
            chk("cyc_borrow", 32'(borrow), 32'(m_b));
            chk("cyc_busy", 32'(busy), 32'(m_left != 0));
            chk("cyc_done", 32'(done), 32'(m_done));
`ifdef OVERFLOW_FLAG_EN
            chk("cyc_overflow", 32'(overflow), 32'(m_o));
`endif
        end
    end

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ez, input logic eb, input logic eo);
        int busy_cycles;
        bit seen;
        busy_cycles = 0;
        seen        = 1'b0;
        x     = a;
        y     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4 * W + 4 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
        chk("op_done_seen", 32'(seen), 32'd1);
        chk("op_busy_cycles", 32'(busy_cycles), 32'(W));
        chk("op_z", 32'(z), 32'(ez));
        chk("op_borrow", 32'(borrow), 32'(eb));
`ifdef OVERFLOW_FLAG_EN
        chk("op_overflow", 32'(overflow), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected unknown overflow expectation");
`endif
        @(negedge clk);
    endtask

    initial begin
        int n_done;

        // T1: reset with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        x     = 4'h9;
        y     = 4'h3;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // T2 / T3: basic and boundary vectors
        run_op(4'h9, 4'h3, 4'h6, 1'b0, 1'b1);
        run_op(4'h0, 4'h1, 4'hF, 1'b1, 1'b0);
        run_op(4'h3, 4'hA, 4'h9, 1'b1, 1'b1);
        run_op(4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        run_op(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        run_op(4'h5, 4'h5, 4'h0, 1'b0, 1'b0);

        // T4: start held through busy, operands changed mid-shift, back-to-back in DONE
        x     = 4'h9;
        y     = 4'h3;
        start = 1'b1;
        @(negedge clk);
        x      = 4'h2;
        y      = 4'h5;
        n_done = 0;
        for (int i = 0; i < 3 * W; i++) begin
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    chk("b2b_first_z", 32'(z), 32'h6);
                    chk("b2b_first_busy", 32'(busy), 32'd0);
                end else begin
                    chk("b2b_second_z", 32'(z), 32'hD);
                    chk("b2b_second_borrow", 32'(borrow), 32'd1);
                end
            end else if (n_done == 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(n_done), 32'd2);

        // T5: reset two cycles into SHIFT aborts the operation
        x     = 4'hF;
        y     = 4'h1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_z", 32'(z), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        run_op(4'h7, 4'h2, 4'h5, 1'b0, 1'b0);

        // T6: signed overflow vectors
        run_op(4'h8, 4'h1, 4'h7, 1'b0, 1'b1);
        run_op(4'h7, 4'hF, 4'h8, 1'b1, 1'b1);
        run_op(4'h5, 4'h3, 4'h2, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
